byteswap_axis_fifo: RTL and testbench
=====================================

# byteswap_axis_fifo

Synchronous AXI4-Stream buffer placed directly downstream of the byteswap swapper stage. The swapper registers `tready` with pipeline delay and keeps presenting beats for up to two cycles after the sink deasserts ready. This block provides headroom for those beats, applies clean backpressure, and presents a standard registered AXI4-Stream master to the kernel's write path. An optional statistics block counts beats and packets delivered.

## Interface
- `C_AXIS_TDATA_WIDTH`, 512: stream data width; `tkeep` is `C_AXIS_TDATA_WIDTH/8`.
- `C_DEPTH`, 32: storage entries, power of two, ≥ 8.
- `C_HEADROOM`, 4: free entries reserved for in-flight beats; must be ≥ 3 and < `C_DEPTH`.
- `s_axis_aclk` in 1: single clock for both interfaces.
- `s_axis_areset` in 1: synchronous reset, active-high (one clock; reset synchronous, active-high).
- `s_axis_tvalid` in 1: upstream beat valid.
- `s_axis_tready` out 1: registered ready, advisory to upstream.
- `s_axis_tdata` in `C_AXIS_TDATA_WIDTH`: upstream data.
- `s_axis_tkeep` in `C_AXIS_TDATA_WIDTH/8`: upstream keep.
- `s_axis_tlast` in 1: upstream end of packet.
- `m_axis_tvalid` out 1: output beat valid.
- `m_axis_tready` in 1: downstream ready.
- `m_axis_tdata` out `C_AXIS_TDATA_WIDTH`: output data.
- `m_axis_tkeep` out `C_AXIS_TDATA_WIDTH/8`: output keep.
- `m_axis_tlast` out 1: output end of packet.
- `overflow` out 1: sticky; set when a beat arrives while storage is full.
- `stat_beats` out 32: beats delivered on m_axis. Present only with `BYTESWAP_FIFO_STATS_EN`.
- `stat_pkts` out 32: `tlast` beats delivered on m_axis. Present only with `BYTESWAP_FIFO_STATS_EN`.

## Operation
- **Storage:** circular array of `C_DEPTH` entries holding {tdata, tkeep, tlast}. It uses a write pointer, a read pointer, and a `$clog2(C_DEPTH)+1`-bit occupancy count. Pointers wrap modulo `C_DEPTH`.
- **Write rule:** a beat is written whenever `s_axis_tvalid=1` and count < `C_DEPTH`, regardless of `s_axis_tready`. Upstream does not honour ready promptly, so ready is advisory only.
- **Overflow:** `s_axis_tvalid=1` with count == `C_DEPTH` drops the beat and sets `overflow`. `overflow` clears only on reset. Pointers and count are unchanged.
- **Ready:** `s_axis_tready` is registered as (`C_DEPTH` − count_next) > `C_HEADROOM`, where count_next is the occupancy after this cycle's write and read.
- **Output stage:** one register slice holds the current beat, with state EMPTY or FULL.
  - EMPTY → FULL when count > 0; the head entry is loaded and the read pointer advances.
  - FULL with handshake (`m_axis_tvalid & m_axis_tready`) and count > 0: reload the next entry and stay FULL.
  - FULL with handshake and count == 0: go to EMPTY.
  - FULL without handshake: hold all m_axis outputs stable (AXI rule).
- **Simultaneous write and read of the array:** count is unchanged. A write into an empty array cannot be read in the same cycle; no combinational bypass is allowed.
- `tkeep` and `tlast` are carried untouched. Packet boundaries are not interpreted except by the statistics counters.

## Timing
- **Reset:** while `s_axis_areset=1` at an edge, the following are cleared: pointers, count, and output state (EMPTY).
  - Outputs after reset: `m_axis_tvalid=0`, `m_axis_tdata=0`, `m_axis_tkeep=0`, `m_axis_tlast=0`, `s_axis_tready=0`, `overflow=0`, `stat_beats=0`, `stat_pkts=0`.
  - `s_axis_tready` rises on the first edge after reset deasserts.
- **Reset mid-packet:** all stored beats are discarded and there is no partial flush. Inputs during reset are ignored.
- **Latency:** a beat accepted at edge k into an empty block is written at k. It loads the output register at k+1, and `m_axis_tvalid=1` from k+1.
- **Throughput:** 1 beat/cycle sustained when `m_axis_tready=1`.
- **Ready deassertion:** `s_axis_tready` falls on the edge where free entries drop to ≤ `C_HEADROOM`. Up to `C_HEADROOM` further beats are absorbed without loss.
- **Count rules:** count never exceeds `C_DEPTH` and never goes negative. The output register is not counted in `count`.

## Configuration
- `BYTESWAP_FIFO_STATS_EN` defined:
  - `stat_beats` increments on every m_axis handshake.
  - `stat_pkts` increments on every handshake with `m_axis_tlast=1`.
  - Both wrap at 2^32 and reset to 0.
- `BYTESWAP_FIFO_STATS_EN` undefined: the counters are not built, and `stat_beats` and `stat_pkts` are driven constant 0.

## Test plan
- **Reset:** hold `s_axis_areset` 3 cycles with random inputs. Required: all outputs 0 during reset; `s_axis_tready=1` one edge after release; `m_axis_tvalid=0`.
- **Latency:** send a single beat (tdata=0x…A5, tkeep=all-ones, tlast=1) with `m_axis_tready=1`. Required: `m_axis_tvalid=1` the cycle after acceptance, data identical, `stat_pkts=1`.
- **Backpressure and headroom:** `C_DEPTH=32`, `C_HEADROOM=4`, `m_axis_tready=0`, continuous tvalid. Required: `s_axis_tready` falls after 28 stored beats; 2 more beats delivered after the fall are stored; `overflow=0`.
- **Overflow:** same setup, but ignore ready and push 40 beats. Required: 32 in the array plus 1 in the output register, `overflow=1`, remaining beats dropped. The drain returns sequence 0..32 in order.
- **Streaming with random ready:** 1000 beats, 10-beat packets, random 50% `m_axis_tready`. Required: bit-exact in-order data, keep, and last; `stat_beats=1000`, `stat_pkts=100`; m_axis held stable while stalled.
- **Mid-stream reset:** 5 beats buffered, then a 1-cycle reset. Required: `m_axis_tvalid=0` next cycle; the next packet passes cleanly with no stale beats.

Source files
------------

// File: rtl/byteswap_axis_fifo_if.sv
// AXI4-Stream bundle used on both sides of byteswap_axis_fifo.
// W is the tdata width; tkeep is W/8 bits.
interface byteswap_axis_fifo_if #(
    parameter int W = 512
) ();
    logic           tvalid;
    logic           tready;
    logic [W-1:0]   tdata;
    logic [W/8-1:0] tkeep;
    logic           tlast;

    modport master (
        output tvalid, tdata, tkeep, tlast,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tlast,
        output tready
    );
endinterface

// File: rtl/byteswap_axis_fifo.sv
// Headroom AXI4-Stream FIFO behind the byteswap swapper, registered output slice.
// Optional beat/packet counters: define BYTESWAP_FIFO_STATS_EN.
module byteswap_axis_fifo #(
    parameter int C_AXIS_TDATA_WIDTH = 512,
    parameter int C_DEPTH            = 32,
    parameter int C_HEADROOM         = 4
) (
    input  logic                 s_axis_aclk,
    input  logic                 s_axis_areset,
    byteswap_axis_fifo_if.slave  s_axis,
    byteswap_axis_fifo_if.master m_axis,
    output logic                 overflow,
    output logic [31:0]          stat_beats,
    output logic [31:0]          stat_pkts
);
    localparam int DW = C_AXIS_TDATA_WIDTH;
    localparam int KW = DW / 8;
    localparam int EW = DW + KW + 1;
    localparam int AW = $clog2(C_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(C_DEPTH);
    localparam logic [CW-1:0] HEAD_C  = CW'(C_HEADROOM);

    typedef enum logic {
        S_EMPTY,
        S_FULL
    } state_t;

    state_t state_q, state_d;

    logic [EW-1:0] mem_q [C_DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          s_ready_q, s_ready_d;
    logic          ovf_q, ovf_d;
    logic [DW-1:0] data_q, data_d;
    logic [KW-1:0] keep_q, keep_d;
    logic          last_q, last_d;

    logic full;
    logic avail;
    logic wr_en;
    logic rd_en;
    logic hs;

    assign full  = (count_q == DEPTH_C);
    assign avail = (count_q != '0);
    assign wr_en = s_axis.tvalid & ~full;
    assign hs    = (state_q == S_FULL) & m_axis.tready;

    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: if (avail) state_d = S_FULL;
            S_FULL:  if (hs && !avail) state_d = S_EMPTY;
        endcase
    end

    // The slice reloads from the array only; a same-cycle write is never bypassed.
    always_comb begin
        rd_en = 1'b0;
        case (state_q)
            S_EMPTY: rd_en = avail;
            S_FULL:  rd_en = hs & avail;
        endcase
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q + AW'(wr_en);
        rd_ptr_d  = rd_ptr_q + AW'(rd_en);
        count_d   = count_q + CW'(wr_en) - CW'(rd_en);
        ovf_d     = ovf_q | (s_axis.tvalid & full);
        s_ready_d = (DEPTH_C - count_d) > HEAD_C;
        data_d    = data_q;
        keep_d    = keep_q;
        last_d    = last_q;
        if (rd_en) begin
            {data_d, keep_d, last_d} = mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            s_ready_q <= 1'b0;
            ovf_q     <= 1'b0;
            data_q    <= '0;
            keep_q    <= '0;
            last_q    <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            s_ready_q <= s_ready_d;
            ovf_q     <= ovf_d;
            data_q    <= data_d;
            keep_q    <= keep_d;
            last_q    <= last_d;
        end
    end

    always_ff @(posedge s_axis_aclk) begin
        if (wr_en && !s_axis_areset) begin
            mem_q[wr_ptr_q] <= {s_axis.tdata, s_axis.tkeep, s_axis.tlast};
        end
    end

    assign s_axis.tready = s_ready_q;
    assign m_axis.tvalid = (state_q == S_FULL);
    assign m_axis.tdata  = data_q;
    assign m_axis.tkeep  = keep_q;
    assign m_axis.tlast  = last_q;
    assign overflow      = ovf_q;

`ifdef BYTESWAP_FIFO_STATS_EN
    logic [31:0] beats_q, beats_d;
    logic [31:0] pkts_q, pkts_d;

    always_comb begin
        beats_d = beats_q + 32'(hs);
        pkts_d  = pkts_q + 32'(hs & last_q);
    end

    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            beats_q <= '0;
            pkts_q  <= '0;
        end else begin
            beats_q <= beats_d;
            pkts_q  <= pkts_d;
        end
    end

    assign stat_beats = beats_q;
    assign stat_pkts  = pkts_q;
`else
    assign stat_beats = '0;
    assign stat_pkts  = '0;
`endif
endmodule

// File: tb/tb_byteswap_axis_fifo.sv
// Scoreboard bench for byteswap_axis_fifo: directed beats in, monitor pops and compares.
// Covers reset, latency, headroom, overflow, random-ready streaming, mid-stream reset.
module tb_byteswap_axis_fifo;
    localparam int W = 64;

`ifdef BYTESWAP_FIFO_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        logic [W-1:0]   d;
        logic [W/8-1:0] k;
        logic           l;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        overflow;
    logic [31:0] stat_beats;
    logic [31:0] stat_pkts;

    byteswap_axis_fifo_if #(.W(W)) s_if ();
    byteswap_axis_fifo_if #(.W(W)) m_if ();

    byteswap_axis_fifo #(
        .C_AXIS_TDATA_WIDTH(W),
        .C_DEPTH(32),
        .C_HEADROOM(4)
    ) dut (
        .s_axis_aclk  (clk),
        .s_axis_areset(rst),
        .s_axis       (s_if),
        .m_axis       (m_if),
        .overflow     (overflow),
        .stat_beats   (stat_beats),
        .stat_pkts    (stat_pkts)
    );

    beat_t sb[$];
    int    applied;
    int    miscompares;
    bit    m_rand;
    bit    m_fix;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] d, input logic [7:0] k,
                         input logic l, input bit keep_it);
        beat_t b;
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tkeep  = k;
        s_if.tlast  = l;
        if (keep_it) begin
            b.d = d;
            b.k = k;
            b.l = l;
            sb.push_back(b);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_if.tvalid = 1'b0;
        sb.delete();
        cyc();
        rst = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            cyc();
            n++;
        end
        repeat (3) cyc();
        chk(nm, 64'(sb.size()), 64'd0);
    endtask

    // Downstream ready driver, applied mid-cycle after the stimulus settles.
    initial begin
        m_if.tready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            m_if.tready = m_rand ? 1'($urandom_range(0, 1)) : m_fix;
        end
    end

    // Monitor: compares delivered beats and checks AXI hold while stalled.
    initial begin
        beat_t          e;
        bit             stall;
        logic [W-1:0]   hd;
        logic [W/8-1:0] hk;
        logic           hl;
        stall = 1'b0;
        hd = '0;
        hk = '0;
        hl = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    chk("hold_valid", 64'(m_if.tvalid), 64'd1);
                    chk("hold_data", m_if.tdata, hd);
                    chk("hold_keep", 64'(m_if.tkeep), 64'(hk));
                    chk("hold_last", 64'(m_if.tlast), 64'(hl));
                end
                if (m_if.tvalid && m_if.tready) begin
                    if (sb.size() == 0) begin
                        applied++;
                        miscompares++;
                        $display("FAIL unexpected_beat: got data %0h expected none",
                                 m_if.tdata);
                    end else begin
                        e = sb.pop_front();
                        chk("out_data", m_if.tdata, e.d);
                        chk("out_keep", 64'(m_if.tkeep), 64'(e.k));
                        chk("out_last", 64'(m_if.tlast), 64'(e.l));
                    end
                end
                stall = m_if.tvalid && !m_if.tready;
                hd = m_if.tdata;
                hk = m_if.tkeep;
                hl = m_if.tlast;
            end
        end
    end

    initial begin
        int i;
        int guard;
        applied = 0;
        miscompares = 0;
        m_rand = 1'b0;
        m_fix = 1'b0;
        rst = 1'b1;
        s_if.tvalid = 1'b0;
        s_if.tdata = '0;
        s_if.tkeep = '0;
        s_if.tlast = 1'b0;

        // Reset held 3 cycles with random inputs.
        for (int r = 0; r < 3; r++) begin
            s_if.tvalid = 1'($urandom_range(0, 1));
            s_if.tdata = {$urandom, $urandom};
            s_if.tkeep = 8'($urandom);
            s_if.tlast = 1'($urandom_range(0, 1));
            cyc();
            chk("rst_m_valid", 64'(m_if.tvalid), 64'd0);
            chk("rst_m_data", m_if.tdata, 64'd0);
            chk("rst_m_keep", 64'(m_if.tkeep), 64'd0);
            chk("rst_m_last", 64'(m_if.tlast), 64'd0);
            chk("rst_s_ready", 64'(s_if.tready), 64'd0);
            chk("rst_overflow", 64'(overflow), 64'd0);
            chk("rst_stat_beats", 64'(stat_beats), 64'd0);
            chk("rst_stat_pkts", 64'(stat_pkts), 64'd0);
        end
        rst = 1'b0;
        s_if.tvalid = 1'b0;
        cyc();
        chk("post_rst_ready", 64'(s_if.tready), 64'd1);
        chk("post_rst_valid", 64'(m_if.tvalid), 64'd0);

        // Single-beat latency.
        m_fix = 1'b1;
        drive(64'h0123_4567_89AB_CDA5, 8'hFF, 1'b1, 1'b1);
        cyc();
        s_if.tvalid = 1'b0;
        chk("lat_no_bypass", 64'(m_if.tvalid), 64'd0);
        cyc();
        chk("lat_valid", 64'(m_if.tvalid), 64'd1);
        chk("lat_data", m_if.tdata, 64'h0123_4567_89AB_CDA5);
        cyc();
        chk("lat_stat_beats", 64'(stat_beats), STATS ? 64'd1 : 64'd0);
        chk("lat_stat_pkts", 64'(stat_pkts), STATS ? 64'd1 : 64'd0);
        chk("lat_empty_after", 64'(m_if.tvalid), 64'd0);

        // Backpressure: ready drops once 28 beats sit in the array.
        m_fix = 1'b0;
        do_reset();
        cyc();
        for (int b = 0; b < 31; b++) begin
            drive(64'h1000 + 64'(b), 8'(b), b == 30, 1'b1);
            cyc();
            if (b == 27) chk("bp_ready_27", 64'(s_if.tready), 64'd1);
            if (b == 28) chk("bp_ready_28", 64'(s_if.tready), 64'd0);
        end
        s_if.tvalid = 1'b0;
        cyc();
        chk("bp_no_overflow", 64'(overflow), 64'd0);
        chk("bp_ready_low", 64'(s_if.tready), 64'd0);
        m_fix = 1'b1;
        drain("bp_drain");

        // Overflow: 40 beats ignoring ready; beats 0..32 survive.
        m_fix = 1'b0;
        do_reset();
        cyc();
        for (int b = 0; b < 40; b++) begin
            drive(64'd200 + 64'(b), 8'h0F, (b % 8) == 7, b <= 32);
            cyc();
        end
        s_if.tvalid = 1'b0;
        cyc();
        chk("ovf_set", 64'(overflow), 64'd1);
        chk("ovf_head", m_if.tdata, 64'd200);
        chk("ovf_ready", 64'(s_if.tready), 64'd0);
        m_fix = 1'b1;
        drain("ovf_drain");
        chk("ovf_sticky", 64'(overflow), 64'd1);

        // Streaming 1000 beats, 10-beat packets, random downstream ready.
        do_reset();
        cyc();
        chk("str_ovf_cleared", 64'(overflow), 64'd0);
        m_rand = 1'b1;
        i = 0;
        guard = 0;
        while (i < 1000 && guard < 20000) begin
            if (s_if.tready) begin
                drive({32'(i) ^ 32'hDEAD_0000, 32'(i)},
                      8'(i) | 8'h01, (i % 10) == 9, 1'b1);
                i++;
            end else begin
                s_if.tvalid = 1'b0;
            end
            cyc();
            guard++;
        end
        s_if.tvalid = 1'b0;
        chk("str_sent", 64'(i), 64'd1000);
        drain("str_drain");
        m_rand = 1'b0;
        m_fix = 1'b1;
        chk("str_stat_beats", 64'(stat_beats), STATS ? 64'd1000 : 64'd0);
        chk("str_stat_pkts", 64'(stat_pkts), STATS ? 64'd100 : 64'd0);
        chk("str_no_overflow", 64'(overflow), 64'd0);

        // Mid-stream reset discards buffered beats.
        m_fix = 1'b0;
        cyc();
        for (int b = 0; b < 5; b++) begin
            drive(64'hBAD0 + 64'(b), 8'hFF, 1'b0, 1'b0);
            cyc();
        end
        s_if.tvalid = 1'b0;
        cyc();
        chk("mid_buffered", 64'(m_if.tvalid), 64'd1);
        do_reset();
        chk("mid_valid_low", 64'(m_if.tvalid), 64'd0);
        cyc();
        chk("mid_ready", 64'(s_if.tready), 64'd1);
        chk("mid_still_empty", 64'(m_if.tvalid), 64'd0);
        m_fix = 1'b1;
        for (int b = 0; b < 3; b++) begin
            drive(64'hC0 + 64'(b), 8'h3C, b == 2, 1'b1);
            cyc();
        end
        s_if.tvalid = 1'b0;
        drain("mid_drain");
        repeat (5) cyc();
        chk("mid_stat_beats", 64'(stat_beats), STATS ? 64'd3 : 64'd0);
        chk("mid_stat_pkts", 64'(stat_pkts), STATS ? 64'd1 : 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 applied, miscompares);
        $finish;
    end
endmodule
